// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the CPU write path, the TX byte FIFO and the UART transmitter.
// Pure wiring: no storage, no added latency.
// Backpressure is carried by wr_ready (CPU side) and tx_data_ready (transmitter side).
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_valid;
    logic [7:0]            wr_data;
    logic                  wr_ready;
    logic [7:0]            tx_data;
    logic                  tx_data_valid;
    logic                  tx_data_ready;
    logic [DEPTH_LOG2:0]   fifo_level;
    logic                  fifo_empty;
    logic                  overflow;
    logic                  overflow_clr;

    // Environment side: CPU writer plus transmitter.
    modport master (
        output wr_valid, wr_data, tx_data_ready, overflow_clr,
        input  wr_ready, tx_data, tx_data_valid, fifo_level, fifo_empty, overflow
    );

    // FIFO side.
    modport slave (
        input  wr_valid, wr_data, tx_data_ready, overflow_clr,
        output wr_ready, tx_data, tx_data_valid, fifo_level, fifo_empty, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter; optional LF->CRLF (UART_TX_FIFO_CRLF_EN).
// Latency: byte written in cycle N is presented on tx_data_valid in cycle N+1.
// Backpressure: wr_ready = !full from the registered level only; writes while full are dropped and flagged.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  ovf_q;

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       hs;
    logic       head_done;
    logic       wr_drop;
    logic [7:0] head;

    assign head    = mem[rd_ptr];
    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign push    = bus.wr_valid & ~full;
    assign wr_drop = bus.wr_valid & full;
    // Any transmitter acceptance; only the final beat of an entry retires it.
    assign hs      = ~empty & bus.tx_data_ready;
    assign pop     = hs & head_done;

`ifdef UART_TX_FIFO_CRLF_EN
    localparam logic [0:0] CR_IDLE = 1'b0;
    localparam logic [0:0] CR_SENT = 1'b1;

    logic [0:0] cr_state;
    logic       lf_head;

    assign lf_head   = (head == 8'h0A);
    // An LF head needs a CR beat first; the stored LF goes out on the second beat.
    assign head_done = ~lf_head | (cr_state == CR_SENT);
    assign bus.tx_data = head_done ? head : 8'h0D;

    // Track whether the CR for the current LF head has already been accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_state <= CR_IDLE;
        end else if (hs) begin
            cr_state <= head_done ? CR_IDLE : CR_SENT;
        end
    end
`else
    assign head_done   = 1'b1;
    assign bus.tx_data = head;
`endif

    // Byte storage; contents are only meaningful between rd_ptr and wr_ptr, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Stored-byte count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow; a dropped write beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (wr_drop) begin
            ovf_q <= 1'b1;
        end else if (bus.overflow_clr) begin
            ovf_q <= 1'b0;
        end
    end

    // Valid derives from the async-reset level, so it drops immediately with rst_n.
    assign bus.wr_ready      = ~full;
    assign bus.tx_data_valid = ~empty;
    assign bus.fifo_level    = level;
    assign bus.fifo_empty    = empty;
    assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic against a queue model.
// Stimulus is driven 1 ns after the rising edge; the monitor samples on the falling edge.
// The transmitter is modelled by driving tx_data_ready in pulses or continuously.
module tb_uart_tx_fifo;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic clk;
    logic rst_n;

    uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bytes the FIFO should hold, sticky overflow, CR-already-sent flag.
    logic [7:0] mdl [$];
    logic       m_ovf;
    logic       m_cr;
    int         m_n;
    logic [7:0] m_out;
    logic       m_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the model, then advance the model by this cycle's inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            mdl.delete();
            m_ovf = 1'b0;
            m_cr  = 1'b0;
        end else begin
            m_n = mdl.size();
            chk("fifo_level", 32'(bus.fifo_level), 32'(m_n));
            chk("fifo_empty", 32'(bus.fifo_empty), 32'(m_n == 0));
            chk("wr_ready", 32'(bus.wr_ready), 32'(m_n < DEPTH));
            chk("tx_data_valid", 32'(bus.tx_data_valid), 32'(m_n != 0));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            if (m_n != 0) begin
                m_out  = mdl[0];
                m_last = 1'b1;
`ifdef UART_TX_FIFO_CRLF_EN
                if (mdl[0] == 8'h0A && !m_cr) begin
                    m_out  = 8'h0D;
                    m_last = 1'b0;
                end
`endif
                chk("tx_data", 32'(bus.tx_data), 32'(m_out));
                if (bus.tx_data_ready) begin
                    if (m_last) begin
                        void'(mdl.pop_front());
                        m_cr = 1'b0;
                    end else begin
                        m_cr = 1'b1;
                    end
                end
            end
            if (bus.wr_valid) begin
                if (m_n < DEPTH) mdl.push_back(bus.wr_data);
                else             m_ovf = 1'b1;
            end
            if (!(bus.wr_valid && m_n >= DEPTH) && bus.overflow_clr) m_ovf = 1'b0;
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic drive(input logic wv, input logic [7:0] wd, input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        bus.wr_valid      = wv;
        bus.wr_data       = wd;
        bus.tx_data_ready = rdy;
        bus.overflow_clr  = clr;
    endtask

    // Transmitter-style drain: ready pulses every other cycle, bounded.
    task automatic drain(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            if (mdl.size() == 0 && bus.fifo_level == 0) break;
            drive(1'b0, 8'h00, (i % 2) == 0, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk(name, 32'(bus.fifo_level), 32'd0);
    endtask

    function automatic logic [7:0] rnd_no_lf();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0A) b = 8'h0B;
        return b;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_valid      = 1'b0;
        bus.wr_data       = 8'h00;
        bus.tx_data_ready = 1'b0;
        bus.overflow_clr  = 1'b0;
        rst_n             = 1'b0;

        // Reset state.
        #2;
        chk("rst_valid", 32'(bus.tx_data_valid), 32'd0);
        chk("rst_level", 32'(bus.fifo_level), 32'd0);
        chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Three back-to-back writes with the transmitter stalled, then drain in order.
        drive(1'b1, 8'h41, 1'b0, 1'b0);
        drive(1'b1, 8'h42, 1'b0, 1'b0);
        drive(1'b1, 8'h43, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("abc_level", 32'(bus.fifo_level), 32'd3);
        chk("abc_head", 32'(bus.tx_data), 32'h41);
        drain("abc_drained");

        // Fill to full, one dropped write, then clear the sticky flag.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("full_level", 32'(bus.fifo_level), 32'(DEPTH));
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_clr", 32'(bus.overflow), 32'd0);
        // Pop and write together while full: write is still refused.
        drive(1'b1, 8'hDD, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_pop_level", 32'(bus.fifo_level), 32'(DEPTH - 1));
        drain("full_drained");

        // Level 5 with continuous push+pop across many pointer wraps.
        for (int i = 0; i < 5; i++) drive(1'b1, rnd_no_lf(), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b1, rnd_no_lf(), 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("steady_level", 32'(bus.fifo_level), 32'd5);
        drain("steady_drained");

        // LF handling: CR inserted only when the expansion is built in.
        drive(1'b1, 8'h48, 1'b0, 1'b0);
        drive(1'b1, 8'h0A, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lf_level_mid", 32'(bus.fifo_level), 32'd1);
`ifdef UART_TX_FIFO_CRLF_EN
        chk("lf_cr_beat", 32'(bus.tx_data), 32'h0D);
`else
        chk("lf_plain", 32'(bus.tx_data), 32'h0A);
`endif
        drain("lf_drained");

        // Asynchronous reset in the middle of a handshake.
        for (int i = 0; i < 7; i++) drive(1'b1, rnd_no_lf(), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.tx_data_valid), 32'd0);
        chk("arst_level", 32'(bus.fifo_level), 32'd0);
        chk("arst_empty", 32'(bus.fifo_empty), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(bus.tx_data_valid), 32'd1);
        chk("post_rst_data", 32'(bus.tx_data), 32'h5A);
        drain("post_rst_drained");

        // Random traffic biased toward filling, with occasional LFs and clears.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 2) != 0,
                  ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(0, 255)),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0);
        end
        drain("rand_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
